// File: rtl/tick_mon_pkg.sv
// tick_mon_pkg: monitor state encoding and default timing constants shared with the delay generator
package tick_mon_pkg;
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_t;
  localparam int EXP_PERIOD_DEF = 7501;
  localparam int TOL_DEF = 2;
  localparam int CBITS_DEF = 13;
endpackage

// File: rtl/interval_timer.sv
// interval_timer: saturating cycles-since-tick counter with timeout compare
module interval_timer #(
  parameter int CBITS = 13,
  parameter int LIMIT = 7503
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  output logic [CBITS-1:0] gap,
  output logic             timeout
);
  // restart at 1 on tick so the tick cycle's gap equals the interval; hold at all-ones
  always_ff @(posedge clk)
    if (rst) gap <= '0;
    else gap <= tick ? CBITS'(1) : (gap == '1 ? gap : gap + CBITS'(1));
  assign timeout = !tick && gap == CBITS'(LIMIT);
endmodule

// File: rtl/tick_interval_monitor.sv
// tick_interval_monitor: judges tick intervals against EXP_PERIOD+/-TOL, tracks lock (STICKY_FAULT_EN makes FAULT terminal)
module tick_interval_monitor
  import tick_mon_pkg::*;
#(
  parameter int EXP_PERIOD = EXP_PERIOD_DEF,
  parameter int TOL = TOL_DEF,
  parameter int CBITS = CBITS_DEF,
  parameter int LOCK_CNT = 2,
  parameter int TCNT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  output logic [CBITS-1:0]     period,
  output logic                 valid,
  output logic                 early,
  output logic                 miss,
  output logic                 locked,
  output logic                 err,
  output logic [TCNT_BITS-1:0] tick_cnt
);
  localparam int GBITS = $clog2(LOCK_CNT + 1);
  if (EXP_PERIOD + TOL + 1 >= 2 ** CBITS) begin : g_bad_cfg
    $error("CBITS too narrow for EXP_PERIOD+TOL");
  end
  state_t state;
  logic [GBITS-1:0] good_cnt;
  logic [CBITS-1:0] gap;
  logic timeout, early_iv, good_iv;
  interval_timer #(.CBITS(CBITS), .LIMIT(EXP_PERIOD + TOL)) u_tmr (
    .clk(clk), .rst(rst), .tick(tick), .gap(gap), .timeout(timeout)
  );
  assign early_iv = gap < CBITS'(EXP_PERIOD - TOL);
  assign good_iv = !early_iv && gap <= CBITS'(EXP_PERIOD + TOL);
  assign locked = state == LOCKED;
  assign err = state == FAULT;
  // lock FSM with pulse flags, held period and free-running tick count
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      good_cnt <= '0;
      period <= '0;
      valid <= 1'b0;
      early <= 1'b0;
      miss <= 1'b0;
      tick_cnt <= '0;
    end else begin
      valid <= 1'b0;
      early <= 1'b0;
      miss <= 1'b0;
      if (tick) tick_cnt <= tick_cnt + 1'b1;
      case (state)
        IDLE:
          if (tick) begin
            state <= ACQ;
            good_cnt <= '0;
          end
        ACQ:
          if (tick) begin
            valid <= 1'b1;
            period <= gap;
            if (good_iv) begin
              good_cnt <= good_cnt + 1'b1;
              if (good_cnt == GBITS'(LOCK_CNT - 1)) state <= LOCKED;
            end else begin
              good_cnt <= '0;
              early <= early_iv;
            end
          end else if (timeout) begin
            miss <= 1'b1;
            state <= FAULT;
          end
        LOCKED:
          if (tick) begin
            valid <= 1'b1;
            period <= gap;
            if (!good_iv) begin
              early <= early_iv;
              state <= FAULT;
            end
          end else if (timeout) begin
            miss <= 1'b1;
            state <= FAULT;
          end
        default: begin
`ifndef STICKY_FAULT_EN
          if (tick) begin
            state <= ACQ;
            good_cnt <= '0;
          end
`endif
        end
      endcase
    end
endmodule

// File: tb/tb_tick_interval_monitor.sv
// tb_tick_interval_monitor: directed table and sequence checks with a shortened period
module tb_tick_interval_monitor;
  localparam int EXP = 20, TOL = 2, CB = 6, TCB = 4;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0;
  logic [CB-1:0] period;
  logic valid, early, miss, locked, err;
  logic [TCB-1:0] tick_cnt;
  int tests = 0, fails = 0;
  typedef struct {
    int n;
    logic [5:0] p;
    logic v, e, m, l, r;
    logic [3:0] tc;
  } vec_t;
  vec_t t1[5];
  vec_t t2[$];

  tick_interval_monitor #(.EXP_PERIOD(EXP), .TOL(TOL), .CBITS(CB), .LOCK_CNT(2), .TCNT_BITS(TCB)) dut (
    .clk(clk), .rst(rst), .tick(tick), .period(period), .valid(valid), .early(early),
    .miss(miss), .locked(locked), .err(err), .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] obs();
    return {period, valid, early, miss, locked, err, tick_cnt};
  endfunction

  function automatic logic [14:0] ex(logic [5:0] p, logic v, logic e, logic m, logic l, logic r, logic [3:0] tc);
    return {p, v, e, m, l, r, tc};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic t);
    @(negedge clk) tick = t;
    @(posedge clk);
    #1 tick = 1'b0;
  endtask

  task automatic tick_after(input int n);
    repeat (n - 1) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk) begin rst = 1'b1; tick = 1'b0; end
    @(posedge clk);
    #1 chk("reset", 16'(obs()), 16'(ex(0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic run(input vec_t v, input string nm, input int i);
    tick_after(v.n);
    chk($sformatf("%s[%0d]", nm, i), 16'(obs()), 16'(ex(v.p, v.v, v.e, v.m, v.l, v.r, v.tc)));
  endtask

  initial begin
    t1[0] = '{5, 0, 0, 0, 0, 0, 0, 1};
    t1[1] = '{20, 20, 1, 0, 0, 0, 0, 2};
    t1[2] = '{20, 20, 1, 0, 0, 1, 0, 3};
    t1[3] = '{22, 22, 1, 0, 0, 1, 0, 4};
    t1[4] = '{18, 18, 1, 0, 0, 1, 0, 5};
`ifdef STICKY_FAULT_EN
    t2.push_back('{4, 18, 0, 0, 0, 0, 1, 6});
    t2.push_back('{20, 18, 0, 0, 0, 0, 1, 7});
    t2.push_back('{20, 18, 0, 0, 0, 0, 1, 8});
    t2.push_back('{1, 18, 0, 0, 0, 0, 1, 9});
`else
    t2.push_back('{4, 18, 0, 0, 0, 0, 0, 6});
    t2.push_back('{1, 1, 1, 1, 0, 0, 0, 7});
    t2.push_back('{19, 19, 1, 0, 0, 0, 0, 8});
    t2.push_back('{21, 21, 1, 0, 0, 1, 0, 9});
    t2.push_back('{10, 10, 1, 1, 0, 0, 1, 10});
    t2.push_back('{40, 10, 0, 0, 0, 0, 0, 11});
    t2.push_back('{20, 20, 1, 0, 0, 0, 0, 12});
`endif
    do_reset();
    foreach (t1[i]) run(t1[i], "lock", i);
    repeat (21) cyc(1'b0);
    chk("pre_timeout", 16'(obs()), 16'(ex(18, 0, 0, 0, 1, 0, 5)));
    cyc(1'b0);
    chk("miss", 16'(obs()), 16'(ex(18, 0, 0, 1, 0, 1, 5)));
    cyc(1'b0);
    chk("miss_pulse_end", 16'(obs()), 16'(ex(18, 0, 0, 0, 0, 1, 5)));
    foreach (t2[i]) run(t2[i], "fault", i);
    do_reset();
    tick_after(5);
    tick_after(20);
    tick_after(20);
    chk("relock", 16'(locked), 16'd1);
    @(negedge clk) begin rst = 1'b1; tick = 1'b1; end
    @(posedge clk);
    #1 tick = 1'b0;
    chk("rst_wins", 16'(obs()), 16'(ex(0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk) rst = 1'b0;
    tick_after(3);
    chk("idle_first", 16'(obs()), 16'(ex(0, 0, 0, 0, 0, 0, 1)));
    tick_after(20);
    chk("acq_after_rst", 16'(obs()), 16'(ex(20, 1, 0, 0, 0, 0, 2)));
    do_reset();
    repeat (15) cyc(1'b1);
    chk("tcnt15", 16'(tick_cnt), 16'd15);
    cyc(1'b1);
    chk("tcnt_wrap", 16'(tick_cnt), 16'd0);
    cyc(1'b1);
    chk("tcnt_after_wrap", 16'(tick_cnt), 16'd1);
    do_reset();
    repeat (70) cyc(1'b0);
    chk("gap_sat", 16'(dut.u_tmr.gap), 16'd63);
    chk("idle_quiet", 16'(obs()), 16'(ex(0, 0, 0, 0, 0, 0, 0)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
